// File: rtl/hv_timing_decode.sv
// hv_timing_decode
//   Receiver-side video timing decoder. Consumes the HSYN/VSYN/HBLK/VBLK
//   stream of the system timing generator, regenerates active pixel/line
//   positions, measures line/frame totals and active sizes, and reports
//   lock once the timing has stayed stable across consecutive frames.
//   Every register advances only on cycles where PCLK_EN is high.
//
// Ports
//   CLK      in   1  system clock
//   RST_N    in   1  asynchronous active-low reset
//   PCLK_EN  in   1  pixel enable
//   HSYN     in   1  horizontal sync, active low
//   VSYN     in   1  vertical sync, active low
//   HBLK     in   1  horizontal blank, active high
//   VBLK     in   1  vertical blank, active high
//   HPOS     out  9  active pixel index within line
//   VPOS     out  9  active line index within frame
//   DE       out  1  data enable
//   HTOTAL   out 10  measured enables per line
//   VTOTAL   out 10  measured lines per frame
//   HACT     out  9  measured active pixels per line
//   VACT     out  9  measured active lines per frame
//   LOCKED   out  1  timing stable
//
// Lock FSM (evaluated on VSYN falling edges; line timeout overrides)
//   state      | meaning
//   ST_SEARCH  | no usable reference, wait for a frame start
//   ST_MEASURE | capture the first reference (HTOTAL, VTOTAL) pair
//   ST_CHECK   | compare against reference, reload it on mismatch
//   ST_LOCKED  | timing stable, drop out on any mismatch or line variation

module hv_timing_decode #(
  parameter int unsigned TO_LIMIT = 1023
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PCLK_EN,
  input  logic       HSYN,
  input  logic       VSYN,
  input  logic       HBLK,
  input  logic       VBLK,
  output logic [8:0] HPOS,
  output logic [8:0] VPOS,
  output logic       DE,
  output logic [9:0] HTOTAL,
  output logic [9:0] VTOTAL,
  output logic [8:0] HACT,
  output logic [8:0] VACT,
  output logic       LOCKED
);

  localparam logic [9:0] TO_LIM  = 10'(TO_LIMIT);
  localparam logic [9:0] CNT_MAX = 10'h3FF;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_CHECK   = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic       hsyn_q, vsyn_q, hblk_q, vblk_q;
  logic [9:0] hc_q, hc_d, vc_q, vc_d;
  logic [9:0] htotal_q, htotal_d, vtotal_q, vtotal_d;
  logic [8:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic [8:0] hact_q, hact_d, vact_q, vact_d;
  logic       de_q, de_d;
  logic       hvar_q, hvar_d;
  logic [9:0] ref_h_q, ref_v_q;

  logic       hs_fall, vs_fall, hb_rise, vb_rise, timeout;
  logic [9:0] hc_inc, vc_inc, vc_hs;
  logic       hvar_eff, pair_ok, ref_ld;

  assign hs_fall = hsyn_q & ~HSYN;
  assign vs_fall = vsyn_q & ~VSYN;
  assign hb_rise = HBLK & ~hblk_q;
  assign vb_rise = VBLK & ~vblk_q;
  assign timeout = (hc_q == TO_LIM);

  // Both counters saturate; the line length reported on an HSYN edge
  // saturates with them so a very long line never reads back as short.
  assign hc_inc = (hc_q == CNT_MAX) ? hc_q : hc_q + 10'd1;
  assign vc_inc = (vc_q == CNT_MAX) ? vc_q : vc_q + 10'd1;

  // Line count including an HSYN edge landing on this enable, so a
  // coincident HSYN/VSYN edge closes the old frame rather than opening the new.
  assign vc_hs = hs_fall ? vc_inc : vc_q;

  // Line-length variation seen up to and including this enable.
  assign hvar_eff = hvar_q | (hs_fall & (hc_inc != htotal_q));

  always_comb begin
    hc_d     = hs_fall ? 10'd0 : hc_inc;
    htotal_d = hs_fall ? hc_inc : htotal_q;
    hvar_d   = vs_fall ? 1'b0 : hvar_eff;
    vc_d     = vs_fall ? 10'd0 : vc_hs;
    vtotal_d = vs_fall ? vc_hs : vtotal_q;
    // HPOS is the index of the pixel just sampled: the first active sample
    // (previous sample still blank) is index 0.
    hpos_d   = (HBLK | hblk_q) ? 9'd0 : hpos_q + 9'd1;
    hact_d   = hb_rise ? hpos_q + 9'd1 : hact_q;
    vpos_d   = vpos_q;
    if (VBLK)         vpos_d = 9'd0;
    else if (hb_rise) vpos_d = vpos_q + 9'd1;
    vact_d   = vb_rise ? vpos_q : vact_q;
    de_d     = ~HBLK & ~VBLK;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hsyn_q   <= 1'b1;
      vsyn_q   <= 1'b1;
      hblk_q   <= 1'b1;
      vblk_q   <= 1'b1;
      hc_q     <= '0;
      vc_q     <= '0;
      htotal_q <= '0;
      vtotal_q <= '0;
      hpos_q   <= '0;
      vpos_q   <= '0;
      hact_q   <= '0;
      vact_q   <= '0;
      de_q     <= 1'b0;
      hvar_q   <= 1'b0;
    end else if (PCLK_EN) begin
      hsyn_q   <= HSYN;
      vsyn_q   <= VSYN;
      hblk_q   <= HBLK;
      vblk_q   <= VBLK;
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      htotal_q <= htotal_d;
      vtotal_q <= vtotal_d;
      hpos_q   <= hpos_d;
      vpos_q   <= vpos_d;
      hact_q   <= hact_d;
      vact_q   <= vact_d;
      de_q     <= de_d;
      hvar_q   <= hvar_d;
    end
  end

  // Lock FSM: state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_SEARCH;
    end else if (PCLK_EN) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ref_h_q <= '0;
      ref_v_q <= '0;
    end else if (PCLK_EN && ref_ld) begin
      ref_h_q <= htotal_d;
      ref_v_q <= vtotal_d;
    end
  end

  // The pair compared is the one this VSYN edge produces.
  assign pair_ok = (htotal_d == ref_h_q) && (vtotal_d == ref_v_q);

  // Lock FSM: next state
  always_comb begin
    state_d = state_q;
    ref_ld  = 1'b0;
    if (timeout) begin
      state_d = ST_SEARCH;
    end else if (vs_fall) begin
      case (state_q)
        ST_SEARCH: state_d = ST_MEASURE;
        ST_MEASURE: begin
          ref_ld  = 1'b1;
          state_d = ST_CHECK;
        end
        ST_CHECK: begin
          if (pair_ok && !hvar_eff) begin
            state_d = ST_LOCKED;
          end else begin
            ref_ld  = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!pair_ok || hvar_eff) state_d = ST_SEARCH;
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  // Lock FSM: outputs
  always_comb begin
    LOCKED = 1'b0;
    if (state_q == ST_LOCKED) LOCKED = 1'b1;
  end

  assign HPOS   = hpos_q;
  assign VPOS   = vpos_q;
  assign DE     = de_q;
  assign HTOTAL = htotal_q;
  assign VTOTAL = vtotal_q;
  assign HACT   = hact_q;
  assign VACT   = vact_q;

endmodule

// File: tb/tb_hv_timing_decode.sv
// Directed bench for hv_timing_decode. A frame generator drives the sync
// stream one enable at a time; expectations for a sample are queued as that
// sample is driven and compared once the DUT has registered it.
module tb_hv_timing_decode;

  logic       CLK, RST_N, PCLK_EN, HSYN, VSYN, HBLK, VBLK;
  logic [8:0] HPOS, VPOS, HACT, VACT;
  logic [9:0] HTOTAL, VTOTAL;
  logic       DE, LOCKED;

  hv_timing_decode #(.TO_LIMIT(1023)) dut (
    .CLK(CLK), .RST_N(RST_N), .PCLK_EN(PCLK_EN),
    .HSYN(HSYN), .VSYN(VSYN), .HBLK(HBLK), .VBLK(VBLK),
    .HPOS(HPOS), .VPOS(VPOS), .DE(DE),
    .HTOTAL(HTOTAL), .VTOTAL(VTOTAL), .HACT(HACT), .VACT(VACT),
    .LOCKED(LOCKED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam int S_HPOS = 0, S_VPOS = 1, S_DE = 2, S_HTOT = 3, S_VTOT = 4,
                 S_HACT = 5, S_VACT = 6, S_LOCK = 7, S_DECNT = 8;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // frame format
  int htot, hact, hoff, vtot, vact, voff;
  int hsw = 4, vsw = 2;
  int bump_y, skip_y0, skip_n;
  int phase, de_cnt, to_y, to_x;

  task automatic set_small();
    htot = 40; hact = 24; hoff = 8;
    vtot = 10; vact = 6;  voff = 2;
    bump_y = -1; skip_y0 = -1; skip_n = 0;
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    chk_t c;
    c.tag = tag; c.sel = sel; c.exp = exp;
    sb.push_back(c);
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_HPOS:  return 32'(HPOS);
      S_VPOS:  return 32'(VPOS);
      S_DE:    return 32'(DE);
      S_HTOT:  return 32'(HTOTAL);
      S_VTOT:  return 32'(VTOTAL);
      S_HACT:  return 32'(HACT);
      S_VACT:  return 32'(VACT);
      S_LOCK:  return 32'(LOCKED);
      default: return 32'(de_cnt);
    endcase
  endfunction

  task automatic pop_all();
    chk_t c;
    logic [31:0] o;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      o = obs(c.sel);
      vectors++;
      assert (o === c.exp) else begin
        miscompares++;
        $error("FAIL %s: observed %0d expected %0d", c.tag, o, c.exp);
      end
    end
  endtask

  task automatic push_all(input string p, input int hp, input int vp, input int de,
                          input int ht, input int vt, input int ha, input int va,
                          input int lk);
    push({p, "_hpos"}, S_HPOS, hp);
    push({p, "_vpos"}, S_VPOS, vp);
    push({p, "_de"}, S_DE, de);
    push({p, "_htotal"}, S_HTOT, ht);
    push({p, "_vtotal"}, S_VTOT, vt);
    push({p, "_hact"}, S_HACT, ha);
    push({p, "_vact"}, S_VACT, va);
    push({p, "_locked"}, S_LOCK, lk);
  endtask

  task automatic active_checks(input int y, input int x);
    if (y == 1 && x == 0) push("htotal_line", S_HTOT, htot);
    if (y == voff && x == hoff) begin
      push("first_px_de", S_DE, 1);
      push("first_px_hpos", S_HPOS, 0);
      push("first_px_vpos", S_VPOS, 0);
    end
    if (y == voff && x == hoff + hact) push("hact", S_HACT, hact);
    if (y == voff + vact - 1 && x == hoff + hact - 1) begin
      push("last_px_hpos", S_HPOS, hact - 1);
      push("last_px_vpos", S_VPOS, vact - 1);
      push("last_px_de", S_DE, 1);
    end
    if (y == voff + vact - 1 && x == hoff + hact) push("de_after_active", S_DE, 0);
    if (y == voff + 1 && x == htot - 1) push("de_count_line", S_DECNT, hact);
    if (y == voff + vact && x == 0) push("vact", S_VACT, vact);
  endtask

  task automatic plan(input int y, input int x);
    bit first, last;
    first = (y == 0 && x == 0);
    last  = (y == vtot - 1 && x == htot - 1);
    if (phase == 3 || phase == 4 || phase == 14 || phase == 15) active_checks(y, x);
    case (phase)
      2: if (last) push("lock_low_before_3rd_edge", S_LOCK, 0);
      3: if (first) begin
        push("lock_3rd_edge", S_LOCK, 1);
        push("htotal_locked", S_HTOT, 40);
        push("vtotal_locked", S_VTOT, 10);
      end
      4: begin
        if (first) push("lock_keep_entry", S_LOCK, 1);
        if (last)  push("lock_hold_h_change", S_LOCK, 1);
      end
      5: if (first) push("lock_keep_h_restore", S_LOCK, 1);
      6: if (first) begin
        push("lock_drop_hvar", S_LOCK, 0);
        push("htotal_after_bump", S_HTOT, 40);
      end
      7, 8, 12, 19: if (last) push("lock_low_relocking", S_LOCK, 0);
      9: if (first) begin
        push("relock_after_hvar", S_LOCK, 1);
        push("relock_htotal", S_HTOT, 40);
      end
      10: begin
        if (first) push("lock_before_timeout", S_LOCK, 1);
        if (y == to_y && x == to_x) begin
          push("lock_at_hc_limit", S_LOCK, 1);
          push("htotal_at_hc_limit", S_HTOT, 40);
        end
        if (y == to_y && x == to_x + 1) begin
          push("timeout_unlock", S_LOCK, 0);
          push("timeout_htotal_hold", S_HTOT, 40);
        end
      end
      13: begin
        if (first) push("relock_after_timeout", S_LOCK, 1);
        if (y == voff + 1 && x == hoff + 6) push("resume_hpos", S_HPOS, 6);
      end
      14: if (first) push("vtotal_small", S_VTOT, 10);
      15: if (first) push("vtotal_wide", S_VTOT, 4);
      16: if (first) push("vtotal_coincident", S_VTOT, 262);
      17: if (first) push("vtotal_restart", S_VTOT, 10);
      18: if (first) begin
        push("vtotal_after_reset", S_VTOT, 6);
        push("lock_after_reset", S_LOCK, 0);
      end
      20: if (first) begin
        push("relock_after_reset", S_LOCK, 1);
        push("relock_rst_htotal", S_HTOT, 40);
        push("relock_rst_vtotal", S_VTOT, 10);
      end
      default: ;
    endcase
  endtask

  task automatic freeze();
    PCLK_EN = 1'b0;
    repeat (50) begin
      HSYN = 1'($urandom_range(0, 1));
      VSYN = 1'($urandom_range(0, 1));
      HBLK = 1'($urandom_range(0, 1));
      VBLK = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
    end
    push_all("freeze", 5, 1, 1, 40, 10, 24, 6, 1);
    pop_all();
  endtask

  task automatic reset_pulse();
    #2 RST_N = 1'b0;
    #1 push_all("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    pop_all();
    #2 RST_N = 1'b1;
  endtask

  task automatic run_frame();
    int len;
    for (int y = 0; y < vtot; y++) begin
      len = (y == bump_y) ? htot + 1 : htot;
      for (int x = 0; x < len; x++) begin
        HSYN = (x < hsw && !(y >= skip_y0 && y < skip_y0 + skip_n)) ? 1'b0 : 1'b1;
        VSYN = (y < vsw) ? 1'b0 : 1'b1;
        HBLK = (x >= hoff && x < hoff + hact) ? 1'b0 : 1'b1;
        VBLK = (y >= voff && y < voff + vact) ? 1'b0 : 1'b1;
        PCLK_EN = 1'b1;
        plan(y, x);
        @(posedge CLK); #1;
        if (y == voff + 1) begin
          if (x == 0) de_cnt = 0;
          de_cnt += int'(DE);
        end
        pop_all();
        if (phase == 13 && y == voff + 1 && x == hoff + 5) freeze();
        if (phase == 17 && y == 4 && x == 10) reset_pulse();
      end
    end
  endtask

  initial begin
    RST_N = 1'b0; PCLK_EN = 1'b0;
    HSYN = 1'b1; VSYN = 1'b1; HBLK = 1'b1; VBLK = 1'b1;
    de_cnt = 0; phase = 0;
    set_small();
    repeat (3) @(posedge CLK);
    #1 push_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    pop_all();
    RST_N = 1'b1;

    // lock from reset: edges at frames 1, 2, 3
    for (int p = 1; p <= 3; p++) begin phase = p; run_frame(); end
    // narrower active area, same totals
    phase = 4; hact = 16; run_frame();
    // one line one enable longer
    phase = 5; hact = 24; bump_y = 5; run_frame();
    bump_y = -1;
    for (int p = 6; p <= 9; p++) begin phase = p; run_frame(); end
    // HSYN missing for many lines -> timeout
    phase = 10; vtot = 40; skip_y0 = 11; skip_n = 28;
    to_y = skip_y0 - 1 + 1023 / htot; to_x = 1023 % htot;
    run_frame();
    set_small();
    for (int p = 11; p <= 13; p++) begin phase = p; run_frame(); end
    // wide lines
    phase = 14; htot = 386; hact = 256; hoff = 64; vtot = 4; vact = 2; voff = 1;
    run_frame();
    // tall frame
    phase = 15; htot = 16; hact = 8; hoff = 4; vtot = 262; vact = 224; voff = 16;
    run_frame();
    set_small();
    for (int p = 16; p <= 20; p++) begin phase = p; run_frame(); end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
